// File: rtl/traffic_phase_ctrl_if.sv
// Control and lamp bus of the traffic phase controller.
// The master drives the control inputs; the controller (slave) drives lamps and status.
interface traffic_phase_ctrl_if #(
    parameter int unsigned NUM_DIRS = 4
);
    localparam int unsigned DIR_W   = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
    localparam int unsigned LIGHT_W = 2 * NUM_DIRS;

    // Control side
    logic               en;
    logic               ped_req;
    logic               flash_mode;

    // Lamp and status side
    logic [LIGHT_W-1:0] light;
    logic [2:0]         state;
    logic [DIR_W-1:0]   active_dir;
    logic               ped_walk;
    logic               ped_pending;

    modport master (
        output en,
        output ped_req,
        output flash_mode,
        input  light,
        input  state,
        input  active_dir,
        input  ped_walk,
        input  ped_pending
    );

    modport slave (
        input  en,
        input  ped_req,
        input  flash_mode,
        output light,
        output state,
        output active_dir,
        output ped_walk,
        output ped_pending
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic phase controller.
// Sequences NUM_DIRS approaches through GREEN/YELLOW/ALLRED, inserts an all-red
// pedestrian walk phase for latched requests, and offers a flashing-yellow mode.
// Lamp outputs are computed from the next-state values and registered, so light,
// state and ped_walk always describe the same cycle.
module traffic_phase_ctrl #(
    parameter int unsigned NUM_DIRS      = 4,
    parameter int unsigned GREEN_CYCLES  = 5,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned ALLRED_CYCLES = 1,
    parameter int unsigned PED_CYCLES    = 3,
    parameter int unsigned FLASH_HALF    = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.slave  bus
);

    localparam int unsigned DIR_W   = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
    localparam int unsigned LIGHT_W = 2 * NUM_DIRS;

    // Phase encodings (externally visible on bus.state)
    localparam logic [2:0] ST_ALLRED = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_PED    = 3'd3;
    localparam logic [2:0] ST_FLASH  = 3'd4;

    // Lamp encodings per approach
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [1:0] LAMP_DARK   = 2'b11;

    // Counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);
    localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIRS - 1);

    // Elaboration-time parameter sanity checks
    generate
        if (NUM_DIRS < 2 || NUM_DIRS > 8) begin : g_bad_dirs
            $error("traffic_phase_ctrl: NUM_DIRS must be in 2..8");
        end
        if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || ALLRED_CYCLES < 1 ||
            PED_CYCLES < 1 || FLASH_HALF < 1) begin : g_bad_dur
            $error("traffic_phase_ctrl: every duration must be at least 1");
        end
        if ((GREEN_CYCLES - 1) >= (2 ** CNT_W) || (YELLOW_CYCLES - 1) >= (2 ** CNT_W) ||
            (ALLRED_CYCLES - 1) >= (2 ** CNT_W) || (PED_CYCLES - 1) >= (2 ** CNT_W) ||
            (FLASH_HALF - 1) >= (2 ** CNT_W)) begin : g_bad_cnt
            $error("traffic_phase_ctrl: CNT_W too narrow for a duration");
        end
    endgenerate

    // Registered state
    logic [2:0]         state_q,    state_nxt;
    logic [CNT_W-1:0]   cnt_q,      cnt_nxt;
    logic [DIR_W-1:0]   dir_q,      dir_nxt;
    logic               flash_ph_q, flash_ph_nxt;
    logic               served_q,   served_nxt;
    logic               pend_q,     pend_nxt;
    logic [LIGHT_W-1:0] light_q,    light_nxt;
    logic               walk_q,     walk_nxt;

    logic               cnt_done;

    assign cnt_done = (cnt_q == '0);

    // Lamp pattern for a given phase, owning approach and flash half-period
    function automatic logic [LIGHT_W-1:0] lamp_pattern(
        input logic [2:0]       st,
        input logic [DIR_W-1:0] dir,
        input logic             ph
    );
        logic [LIGHT_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            case (st)
                ST_GREEN: begin
                    if (DIR_W'(i) == dir) pat[2*i +: 2] = LAMP_GREEN;
                    else                  pat[2*i +: 2] = LAMP_RED;
                end
                ST_YELLOW: begin
                    if (DIR_W'(i) == dir) pat[2*i +: 2] = LAMP_YELLOW;
                    else                  pat[2*i +: 2] = LAMP_RED;
                end
                ST_FLASH: begin
                    pat[2*i +: 2] = ph ? LAMP_DARK : LAMP_YELLOW;
                end
                default: begin
                    pat[2*i +: 2] = LAMP_RED;
                end
            endcase
        end
        return pat;
    endfunction

    // Next-state, counter, pedestrian bookkeeping and next lamp values
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        dir_nxt      = dir_q;
        flash_ph_nxt = flash_ph_q;
        served_nxt   = served_q;
        pend_nxt     = pend_q;

        // Requests latch in every phase but the walk itself, even while frozen
        if (bus.ped_req && (state_q != ST_PED)) begin
            pend_nxt = 1'b1;
        end

        if (bus.en) begin
            case (state_q)
                ST_ALLRED: begin
                    if (cnt_done) begin
                        if (bus.flash_mode) begin
                            state_nxt    = ST_FLASH;
                            cnt_nxt      = FLASH_LD;
                            flash_ph_nxt = 1'b0;
                        end else if ((pend_q || bus.ped_req) && !served_q) begin
                            state_nxt  = ST_PED;
                            cnt_nxt    = PED_LD;
                            pend_nxt   = 1'b0;
                            served_nxt = 1'b1;
                        end else begin
                            state_nxt  = ST_GREEN;
                            cnt_nxt    = GREEN_LD;
                            served_nxt = 1'b0;
                        end
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end

                ST_GREEN: begin
                    // Flash request cuts green short; yellow still runs in full
                    if (cnt_done || bus.flash_mode) begin
                        state_nxt = ST_YELLOW;
                        cnt_nxt   = YELLOW_LD;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end

                ST_YELLOW: begin
                    if (cnt_done) begin
                        state_nxt = ST_ALLRED;
                        cnt_nxt   = ALLRED_LD;
                        dir_nxt   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end

                ST_PED: begin
                    if (cnt_done) begin
                        state_nxt = ST_ALLRED;
                        cnt_nxt   = ALLRED_LD;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end

                ST_FLASH: begin
                    // Leave flashing only on a half-period boundary
                    if (cnt_done) begin
                        if (!bus.flash_mode) begin
                            state_nxt    = ST_ALLRED;
                            cnt_nxt      = ALLRED_LD;
                            flash_ph_nxt = 1'b0;
                        end else begin
                            cnt_nxt      = FLASH_LD;
                            flash_ph_nxt = ~flash_ph_q;
                        end
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_nxt    = ST_ALLRED;
                    cnt_nxt      = ALLRED_LD;
                    flash_ph_nxt = 1'b0;
                end
            endcase
        end

        light_nxt = lamp_pattern(state_nxt, dir_nxt, flash_ph_nxt);
        walk_nxt  = (state_nxt == ST_PED);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ALLRED;
            cnt_q      <= ALLRED_LD;
            dir_q      <= '0;
            flash_ph_q <= 1'b0;
            served_q   <= 1'b0;
            pend_q     <= 1'b0;
            light_q    <= '0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            dir_q      <= dir_nxt;
            flash_ph_q <= flash_ph_nxt;
            served_q   <= served_nxt;
            pend_q     <= pend_nxt;
            light_q    <= light_nxt;
            walk_q     <= walk_nxt;
        end
    end

    assign bus.light       = light_q;
    assign bus.state       = state_q;
    assign bus.active_dir  = dir_q;
    assign bus.ped_walk    = walk_q;
    assign bus.ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl with default parameters.
// Expected per-cycle lamp/status tuples are queued as each scenario is driven
// and popped against the DUT outputs one cycle at a time.
module tb_traffic_phase_ctrl;

    localparam logic [2:0] S_AR  = 3'd0;
    localparam logic [2:0] S_G   = 3'd1;
    localparam logic [2:0] S_Y   = 3'd2;
    localparam logic [2:0] S_PED = 3'd3;
    localparam logic [2:0] S_FL  = 3'd4;

    typedef struct {
        logic [7:0] light;
        logic [2:0] st;
        logic       walk;
        int         dir;
        logic       pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    traffic_phase_ctrl_if #(.NUM_DIRS(4)) bus ();

    traffic_phase_ctrl #(
        .NUM_DIRS(4), .GREEN_CYCLES(5), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1),
        .PED_CYCLES(3), .FLASH_HALF(2), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Queue n cycles of a non-flash phase; lamps follow directly from phase and owner
    task automatic push(input logic [2:0] st, input int dir, input logic pend, input int n);
        exp_t e;
        e.st   = st;
        e.dir  = dir;
        e.pend = pend;
        e.walk = (st == S_PED);
        if (st == S_G)      e.light = 8'h02 << (2 * dir);
        else if (st == S_Y) e.light = 8'h01 << (2 * dir);
        else                e.light = 8'h00;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_flash(input logic [7:0] lt, input int dir, input logic pend, input int n);
        exp_t e;
        e.st    = S_FL;
        e.dir   = dir;
        e.pend  = pend;
        e.walk  = 1'b0;
        e.light = lt;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Pop and compare one expectation per cycle until the queue is empty
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("light@%0d", cyc), 32'(bus.light),       32'(e.light));
            check($sformatf("state@%0d", cyc), 32'(bus.state),       32'(e.st));
            check($sformatf("walk@%0d",  cyc), 32'(bus.ped_walk),    32'(e.walk));
            check($sformatf("dir@%0d",   cyc), 32'(bus.active_dir),  32'(e.dir));
            check($sformatf("pend@%0d",  cyc), 32'(bus.ped_pending), 32'(e.pend));
            step();
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_light"}, 32'(bus.light),       32'h00);
        check({pfx, "_state"}, 32'(bus.state),       32'(S_AR));
        check({pfx, "_dir"},   32'(bus.active_dir),  32'h0);
        check({pfx, "_walk"},  32'(bus.ped_walk),    32'h0);
        check({pfx, "_pend"},  32'(bus.ped_pending), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en         = 1'b1;
        bus.ped_req    = 1'b0;
        bus.flash_mode = 1'b0;

        // Reset values, then release
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;

        // Free run: one all-red, then four G5/Y2/AR1 sequences, wrapping to dir0
        push(S_AR, 0, 1'b0, 1);
        for (int d = 0; d < 4; d++) begin
            push(S_G, d, 1'b0, 5);
            push(S_Y, d, 1'b0, 2);
            push(S_AR, (d + 1) % 4, 1'b0, 1);
        end
        drain();

        // One-cycle ped request during dir0 green
        bus.ped_req = 1'b1;
        push(S_G, 0, 1'b0, 1);
        drain();
        bus.ped_req = 1'b0;
        push(S_G, 0, 1'b1, 4);
        push(S_Y, 0, 1'b1, 2);
        push(S_AR, 1, 1'b1, 1);
        push(S_PED, 1, 1'b0, 3);
        push(S_AR, 1, 1'b0, 1);
        drain();

        // Flash requested on cycle 2 of dir1 green; cleared mid half-period
        push(S_G, 1, 1'b0, 1);
        drain();
        bus.flash_mode = 1'b1;
        push(S_G, 1, 1'b0, 1);
        push(S_Y, 1, 1'b0, 2);
        push(S_AR, 2, 1'b0, 1);
        push_flash(8'h55, 2, 1'b0, 2);
        push_flash(8'hFF, 2, 1'b0, 2);
        push_flash(8'h55, 2, 1'b0, 2);
        drain();
        bus.flash_mode = 1'b0;
        push_flash(8'hFF, 2, 1'b0, 2);
        push(S_AR, 2, 1'b0, 1);
        push(S_G, 2, 1'b0, 5);
        push(S_Y, 2, 1'b0, 2);
        drain();

        // Ped and flash together in the final all-red cycle: flash wins, ped held
        bus.ped_req    = 1'b1;
        bus.flash_mode = 1'b1;
        push(S_AR, 3, 1'b0, 1);
        drain();
        bus.ped_req = 1'b0;
        push_flash(8'h55, 3, 1'b1, 2);
        drain();
        bus.flash_mode = 1'b0;
        push_flash(8'hFF, 3, 1'b1, 2);
        push(S_AR, 3, 1'b1, 1);
        push(S_PED, 3, 1'b0, 3);
        push(S_AR, 3, 1'b0, 1);
        push(S_G, 3, 1'b0, 5);
        push(S_Y, 3, 1'b0, 2);
        drain();

        // Request in the final all-red cycle is served by that exit; requests in PED drop
        bus.ped_req = 1'b1;
        push(S_AR, 0, 1'b0, 1);
        drain();
        push(S_PED, 0, 1'b0, 1);
        drain();
        bus.ped_req = 1'b0;
        push(S_PED, 0, 1'b0, 2);
        push(S_AR, 0, 1'b0, 1);
        drain();

        // Enable low for 10 cycles mid-green; ped request still latches while frozen
        push(S_G, 0, 1'b0, 2);
        drain();
        bus.en = 1'b0;
        push(S_G, 0, 1'b0, 5);
        drain();
        bus.ped_req = 1'b1;
        push(S_G, 0, 1'b0, 1);
        drain();
        bus.ped_req = 1'b0;
        push(S_G, 0, 1'b1, 4);
        drain();
        bus.en = 1'b1;
        push(S_G, 0, 1'b1, 3);
        push(S_Y, 0, 1'b1, 2);
        push(S_AR, 1, 1'b1, 1);
        push(S_PED, 1, 1'b0, 3);
        push(S_AR, 1, 1'b0, 1);
        drain();

        // Asynchronous reset mid-yellow with a pending request
        bus.ped_req = 1'b1;
        push(S_G, 1, 1'b0, 1);
        drain();
        bus.ped_req = 1'b0;
        push(S_G, 1, 1'b1, 4);
        push(S_Y, 1, 1'b1, 1);
        drain();
        #2;
        rst = 1'b1;
        #1;
        check_reset("arst");
        @(posedge clk);
        #4;
        check_reset("arst_hold");
        rst = 1'b0;
        push(S_AR, 0, 1'b0, 1);
        push(S_G, 0, 1'b0, 5);
        push(S_Y, 0, 1'b0, 2);
        push(S_AR, 1, 1'b0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
